execute_stage_mc: RTL and testbench

Parametrised execute stage for the pipelined MIPS datapath, sitting between decode/operand-fetch and write-back. It keeps the single-cycle ALU path through `function_unit` and adds an iterative unsigned multiply/divide unit, a valid/ready handshake on both sides, and a flush input. It replaces fixed 32-bit, always-advancing stage registers with a stallable, width-generic pipeline register.

---
 rtl/exec_pkg.sv | 41 ++++
 rtl/adder.sv | 16 +
 rtl/function_unit.sv | 61 ++++++
 rtl/mul_div_unit.sv | 105 ++++++++++
 rtl/three_to_one_mux.sv | 24 ++
 rtl/execute_stage_mc.sv | 189 ++++++++++++++++++
 tb/tb_execute_stage_mc.sv | 285 ++++++++++++++++++++++++++++
 7 files changed

// File: rtl/exec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exec_pkg                                                                   |
// | Shared encodings for the multi-cycle execute stage.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package exec_pkg;

  localparam logic [1:0] MOP_ALU  = 2'b00;
  localparam logic [1:0] MOP_MUL  = 2'b01;
  localparam logic [1:0] MOP_DIVU = 2'b10;
  localparam logic [1:0] MOP_REMU = 2'b11;

  localparam logic [1:0] MD_ALU  = 2'd0;
  localparam logic [1:0] MD_DATA = 2'd1;
  localparam logic [1:0] MD_SLT  = 2'd2;

  localparam logic [3:0] FS_MOVA = 4'b0000;
  localparam logic [3:0] FS_INC  = 4'b0001;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_SUB  = 4'b0101;
  localparam logic [3:0] FS_DEC  = 4'b0110;
  localparam logic [3:0] FS_AND  = 4'b1000;
  localparam logic [3:0] FS_OR   = 4'b1001;
  localparam logic [3:0] FS_XOR  = 4'b1010;
  localparam logic [3:0] FS_NOT  = 4'b1011;
  localparam logic [3:0] FS_MOVB = 4'b1100;
  localparam logic [3:0] FS_SRL  = 4'b1101;
  localparam logic [3:0] FS_SLL  = 4'b1110;

  // Divide-by-zero quotient is every bit set, at whatever width is in use.
  localparam logic DIVZ_QUOT_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } exec_state_e;

endpackage
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder                                                                      |
// | Plain WIDTH-bit adder, carry discarded.                                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);
  assign sum_o = a_i + b_i;
endmodule
`default_nettype wire

// File: rtl/function_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | function_unit                                                              |
// | Single-cycle ALU/shifter with negative, overflow and zero flags.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module function_unit
  import exec_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int SH_BITS   = 5
) (
  input  logic [DATA_BITS-1:0] a_i,
  input  logic [DATA_BITS-1:0] b_i,
  input  logic [3:0]           fs_i,
  input  logic [SH_BITS-1:0]   sh_i,
  output logic [DATA_BITS-1:0] f_o,
  output logic                 n_o,
  output logic                 v_o,
  output logic                 z_o
);
  logic [DATA_BITS-1:0] opb;
  logic [DATA_BITS-1:0] sum;
  logic                 cin;
  logic                 arith;

  always_comb begin
    opb   = '0;
    cin   = 1'b0;
    arith = 1'b1;
    case (fs_i)
      FS_MOVA: ;
      FS_INC:  cin = 1'b1;
      FS_ADD:  opb = b_i;
      FS_SUB:  begin opb = ~b_i; cin = 1'b1; end
      FS_DEC:  opb = '1;
      default: arith = 1'b0;
    endcase
  end

  assign sum = a_i + opb + {{(DATA_BITS-1){1'b0}}, cin};

  always_comb begin
    case (fs_i)
      FS_AND:  f_o = a_i & b_i;
      FS_OR:   f_o = a_i | b_i;
      FS_XOR:  f_o = a_i ^ b_i;
      FS_NOT:  f_o = ~a_i;
      FS_MOVB: f_o = b_i;
      FS_SRL:  f_o = b_i >> sh_i;
      FS_SLL:  f_o = b_i << sh_i;
      default: f_o = arith ? sum : '0;
    endcase
  end

  assign n_o = f_o[DATA_BITS-1];
  assign v_o = arith && (a_i[DATA_BITS-1] == opb[DATA_BITS-1]) &&
               (sum[DATA_BITS-1] != a_i[DATA_BITS-1]);
  assign z_o = (f_o == '0);
endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_div_unit                                                               |
// | Iterative unsigned shift-add multiply / restoring divide, one bit a cycle. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mul_div_unit
  import exec_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [DATA_BITS-1:0] a_i,
  input  logic [DATA_BITS-1:0] b_i,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DATA_BITS-1:0] value_o
);
  localparam int W  = DATA_BITS;
  localparam int CW = $clog2(DATA_BITS + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d, sh_q, sh_d;
  logic [W:0]    trial;

  // sh_q holds the multiplier (MSB first) or the dividend being consumed
  // while quotient bits shift in behind it.
  assign trial = {acc_q, sh_q[W-1]} - {1'b0, b_q};

  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    if (flush_i) begin
      busy_d  = 1'b0;
      count_d = '0;
    end else if (start_i) begin
      busy_d  = 1'b1;
      count_d = CW'(DATA_BITS);
      op_d    = op_i;
      a_d     = a_i;
      b_d     = b_i;
      acc_d   = '0;
      sh_d    = (op_i == MOP_MUL) ? b_i : a_i;
    end else if (busy_q) begin
      if (count_q == '0) begin
        busy_d = 1'b0;
      end else begin
        count_d = count_q - CW'(1);
        if (op_q == MOP_MUL) begin
          acc_d = {acc_q[W-2:0], 1'b0} + (sh_q[W-1] ? a_q : '0);
          sh_d  = {sh_q[W-2:0], 1'b0};
        end else if (!trial[W]) begin
          acc_d = trial[W-1:0];
          sh_d  = {sh_q[W-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[W-2:0], sh_q[W-1]};
          sh_d  = {sh_q[W-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      count_q <= '0;
      op_q    <= MOP_ALU;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (count_q == '0);

  always_comb begin
    case (op_q)
      MOP_DIVU: value_o = (b_q == '0) ? {DATA_BITS{DIVZ_QUOT_FILL}} : sh_q;
      MOP_REMU: value_o = (b_q == '0) ? a_q : acc_q;
      default:  value_o = acc_q;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/three_to_one_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | three_to_one_mux                                                           |
// | Three-input selector; the unused fourth code returns input 0.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module three_to_one_mux #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  output logic [WIDTH-1:0] y_o
);
  always_comb begin
    case (sel_i)
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      default: y_o = d0_i;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/execute_stage_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | execute_stage_mc                                                           |
// | Stallable execute stage: single-cycle ALU plus iterative MUL/DIVU.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module execute_stage_mc
  import exec_pkg::*;
#(
  parameter int DATA_BITS             = 32,
  parameter int REG_ADDR_WIDTH        = 5,
  parameter int PROGRAM_COUNTER_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             flush,
  input  logic                             RW,
  input  logic [REG_ADDR_WIDTH-1:0]        DA,
  input  logic [1:0]                       MD,
  input  logic [3:0]                       FS,
  input  logic [REG_ADDR_WIDTH-1:0]        SH,
  input  logic [1:0]                       MOP,
  input  logic [DATA_BITS-1:0]             BUSA,
  input  logic [DATA_BITS-1:0]             BUSB,
  input  logic [DATA_BITS-1:0]             DData,
  input  logic [PROGRAM_COUNTER_WIDTH-1:0] pc_min_two,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             RW_WB,
  output logic [REG_ADDR_WIDTH-1:0]        DA_WB,
  output logic [1:0]                       MD_WB,
  output logic [DATA_BITS-1:0]             result,
  output logic [DATA_BITS-1:0]             DData_next,
  output logic                             determinate,
  output logic [DATA_BITS-1:0]             BrA,
  output logic                             zero,
  output logic [DATA_BITS-1:0]             forward_data,
  output logic                             fwd_valid
);
  exec_state_e state_q, state_d;

  logic [DATA_BITS-1:0] alu_f, md_value, pc_ext;
  logic                 alu_n, alu_v, alu_det;
  logic                 md_busy, md_done;
  logic                 slot_free, accept, load_alu, load_md, start_md;

  logic                      out_valid_q, out_valid_d, rw_wb_q, rw_wb_d, det_q, det_d;
  logic [REG_ADDR_WIDTH-1:0] da_wb_q, da_wb_d, pda_q, pda_d;
  logic [1:0]                md_wb_q, md_wb_d, pmd_q, pmd_d;
  logic [DATA_BITS-1:0]      result_q, result_d, dd_q, dd_d, pdd_q, pdd_d;
  logic                      prw_q, prw_d;
  logic                      unused_md_busy;

  function_unit #(.DATA_BITS(DATA_BITS), .SH_BITS(REG_ADDR_WIDTH)) u_fu (
    .a_i(BUSA), .b_i(BUSB), .fs_i(FS), .sh_i(SH),
    .f_o(alu_f), .n_o(alu_n), .v_o(alu_v), .z_o(zero)
  );
  assign alu_det = alu_n ^ alu_v;

  generate
    if (PROGRAM_COUNTER_WIDTH == DATA_BITS) begin : g_pc_full
      assign pc_ext = pc_min_two;
    end else begin : g_pc_pad
      assign pc_ext = {{(DATA_BITS-PROGRAM_COUNTER_WIDTH){1'b0}}, pc_min_two};
    end
  endgenerate

  adder #(.WIDTH(DATA_BITS)) u_bra (.a_i(pc_ext), .b_i(BUSB), .sum_o(BrA));

  three_to_one_mux #(.WIDTH(DATA_BITS)) u_fwd (
    .sel_i(MD), .d0_i(alu_f), .d1_i(DData),
    .d2_i({{(DATA_BITS-1){1'b0}}, alu_det}), .y_o(forward_data)
  );

  mul_div_unit #(.DATA_BITS(DATA_BITS)) u_md (
    .clk(clk), .rst(rst), .start_i(start_md), .op_i(MOP), .a_i(BUSA), .b_i(BUSB),
    .flush_i(flush), .busy_o(md_busy), .done_o(md_done), .value_o(md_value)
  );
  assign unused_md_busy = md_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_md) state_d = ST_BUSY;
      ST_BUSY: if (md_done) state_d = load_md ? ST_IDLE : ST_HOLD;
      ST_HOLD: if (load_md) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    in_ready  = (state_q == ST_IDLE) && slot_free && !flush;
    accept    = in_valid && in_ready;
    load_alu  = accept && (MOP == MOP_ALU);
    start_md  = accept && (MOP != MOP_ALU);
    load_md   = !flush && slot_free &&
                (((state_q == ST_BUSY) && md_done) || (state_q == ST_HOLD));
    fwd_valid = in_valid && (MOP == MOP_ALU) && (state_q == ST_IDLE);
  end

  // Control for a multi-cycle op waits here until its result is ready.
  always_comb begin
    prw_d = prw_q;
    pda_d = pda_q;
    pmd_d = pmd_q;
    pdd_d = pdd_q;
    if (start_md) begin
      prw_d = RW;
      pda_d = DA;
      pmd_d = MD;
      pdd_d = DData;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    rw_wb_d     = rw_wb_q;
    da_wb_d     = da_wb_q;
    md_wb_d     = md_wb_q;
    result_d    = result_q;
    dd_d        = dd_q;
    det_d       = det_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (load_alu) begin
      out_valid_d = 1'b1;
      rw_wb_d     = RW;
      da_wb_d     = DA;
      md_wb_d     = MD;
      result_d    = alu_f;
      dd_d        = DData;
      det_d       = alu_det;
    end else if (load_md) begin
      out_valid_d = 1'b1;
      rw_wb_d     = prw_q;
      da_wb_d     = pda_q;
      md_wb_d     = pmd_q;
      result_d    = md_value;
      dd_d        = pdd_q;
      det_d       = 1'b0;
    end
    if (flush) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rw_wb_q     <= 1'b0;
      da_wb_q     <= '0;
      md_wb_q     <= '0;
      result_q    <= '0;
      dd_q        <= '0;
      det_q       <= 1'b0;
      prw_q       <= 1'b0;
      pda_q       <= '0;
      pmd_q       <= '0;
      pdd_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rw_wb_q     <= rw_wb_d;
      da_wb_q     <= da_wb_d;
      md_wb_q     <= md_wb_d;
      result_q    <= result_d;
      dd_q        <= dd_d;
      det_q       <= det_d;
      prw_q       <= prw_d;
      pda_q       <= pda_d;
      pmd_q       <= pmd_d;
      pdd_q       <= pdd_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign RW_WB       = rw_wb_q;
  assign DA_WB       = da_wb_q;
  assign MD_WB       = md_wb_q;
  assign result      = result_q;
  assign DData_next  = dd_q;
  assign determinate = det_q;
endmodule
`default_nettype wire

// File: tb/tb_execute_stage_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_execute_stage_mc                                                        |
// | Directed self-checking bench for the multi-cycle execute stage.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_execute_stage_mc;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0, RW = 1'b0, out_ready = 1'b0;
  logic [4:0]  DA = '0, SH = '0;
  logic [1:0]  MD = '0, MOP = '0;
  logic [3:0]  FS = '0;
  logic [31:0] BUSA = '0, BUSB = '0, DData = '0, pc_min_two = '0;
  logic        in_ready, out_valid, RW_WB, determinate, zero, fwd_valid;
  logic [4:0]  DA_WB;
  logic [1:0]  MD_WB;
  logic [31:0] result, DData_next, BrA, forward_data;

  int total = 0;
  int bad   = 0;

  execute_stage_mc #(.DATA_BITS(32), .REG_ADDR_WIDTH(5), .PROGRAM_COUNTER_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .RW(RW), .DA(DA), .MD(MD), .FS(FS), .SH(SH), .MOP(MOP),
    .BUSA(BUSA), .BUSB(BUSB), .DData(DData), .pc_min_two(pc_min_two),
    .out_valid(out_valid), .out_ready(out_ready), .RW_WB(RW_WB), .DA_WB(DA_WB),
    .MD_WB(MD_WB), .result(result), .DData_next(DData_next), .determinate(determinate),
    .BrA(BrA), .zero(zero), .forward_data(forward_data), .fwd_valid(fwd_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] mop, input logic [3:0] fs,
                       input logic [31:0] a, input logic [31:0] b, input logic rw,
                       input logic [4:0] da, input logic [1:0] md, input logic [31:0] dd);
    in_valid = v; MOP = mop; FS = fs; BUSA = a; BUSB = b;
    RW = rw; DA = da; MD = md; DData = dd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({out_valid, RW_WB, DA_WB, MD_WB, determinate} !== 10'd0 || result !== 32'd0 ||
        DData_next !== 32'd0) begin
      bad++;
      $display("FAIL reset_regs: got ov=%b rw=%b da=%h md=%h det=%b res=%h dd=%h want all 0",
               out_valid, RW_WB, DA_WB, MD_WB, determinate, result, DData_next);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_add();
    out_ready = 1'b1;
    pc_min_two = 32'd100;
    drive(1'b1, MOP_ALU, FS_ADD, 32'd5, 32'd7, 1'b1, 5'd3, MD_ALU, 32'hDEAD_0001);
    #1;
    total++;
    if (forward_data !== 32'd12 || fwd_valid !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL add_forward: got fwd=%h fv=%b rdy=%b want 0000000c 1 1",
               forward_data, fwd_valid, in_ready);
    end
    total++;
    if (BrA !== 32'd107 || zero !== 1'b0) begin
      bad++; $display("FAIL bra_zero: got bra=%h z=%b want 0000006b 0", BrA, zero);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 32'd12 || DA_WB !== 5'd3 || RW_WB !== 1'b1 ||
        DData_next !== 32'hDEAD_0001 || determinate !== 1'b0) begin
      bad++;
      $display("FAIL add_result: got ov=%b res=%h da=%h rw=%b dd=%h det=%b want 1 0000000c 03 1 dead0001 0",
               out_valid, result, DA_WB, RW_WB, DData_next, determinate);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL add_drain: got ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_slt_zero();
    out_ready = 1'b1;
    drive(1'b1, MOP_ALU, FS_SUB, 32'd5, 32'd5, 1'b0, 5'd1, MD_ALU, 32'd0);
    #1;
    total++;
    if (zero !== 1'b1) begin
      bad++; $display("FAIL sub_zero_flag: got %b want 1", zero);
    end
    drive(1'b1, MOP_ALU, FS_SUB, 32'd3, 32'd5, 1'b1, 5'd2, MD_SLT, 32'd0);
    #1;
    total++;
    if (forward_data !== 32'd1) begin
      bad++; $display("FAIL slt_forward: got %h want 00000001", forward_data);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (determinate !== 1'b1 || result !== 32'hFFFF_FFFE || MD_WB !== MD_SLT) begin
      bad++;
      $display("FAIL slt_result: got det=%b res=%h md=%h want 1 fffffffe 2",
               determinate, result, MD_WB);
    end
    tick();
  endtask

  task automatic test_muldiv(input logic [1:0] mop, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res);
    out_ready = 1'b1;
    drive(1'b1, mop, FS_ADD, a, b, 1'b1, 5'd9, MD_ALU, 32'h1234_5678);
    #1;
    total++;
    if (in_ready !== 1'b1 || fwd_valid !== 1'b0) begin
      bad++; $display("FAIL md_accept mop=%0d: got rdy=%b fv=%b want 1 0", mop, in_ready, fwd_valid);
    end
    tick();
    drive(1'b0, MOP_ALU, FS_ADD, 32'd0, 32'd0, 1'b0, 5'd0, MD_ALU, 32'd0);
    for (int i = 1; i <= 32; i++) begin
      tick();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL md_busy mop=%0d cyc=%0d: got rdy=%b ov=%b want 0 0", mop, i, in_ready, out_valid);
      end
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || result !== exp_res || determinate !== 1'b0 ||
        DA_WB !== 5'd9 || DData_next !== 32'h1234_5678) begin
      bad++;
      $display("FAIL md_result mop=%0d: got ov=%b res=%h det=%b da=%h dd=%h want 1 %h 0 09 12345678",
               mop, out_valid, result, determinate, DA_WB, DData_next, exp_res);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL md_drain mop=%0d: got ov=%b rdy=%b want 0 1", mop, out_valid, in_ready);
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    drive(1'b1, MOP_ALU, FS_ADD, 32'd1, 32'd2, 1'b1, 5'd5, MD_ALU, 32'd0);
    tick();
    drive(1'b1, MOP_ALU, FS_ADD, 32'd10, 32'd20, 1'b1, 5'd6, MD_ALU, 32'd0);
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || result !== 32'd3 || DA_WB !== 5'd5 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d: got ov=%b res=%h da=%h rdy=%b want 1 00000003 05 0",
                 i, out_valid, result, DA_WB, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 32'd30 || DA_WB !== 5'd6) begin
      bad++;
      $display("FAIL bp_second: got ov=%b res=%h da=%h want 1 0000001e 06", out_valid, result, DA_WB);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_drain: got ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    logic seen;
    out_ready = 1'b1;
    drive(1'b1, MOP_MUL, FS_ADD, 32'd3, 32'd4, 1'b1, 5'd7, MD_ALU, 32'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL flush_blocks_ready: got %b want 0", in_ready);
    end
    tick();
    flush = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_ready_after: got %b want 1", in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL flush_no_output: got out_valid seen=%b want 0", seen);
    end
    // Flush and a valid ALU op in the same cycle: flush wins.
    drive(1'b1, MOP_ALU, FS_ADD, 32'd1, 32'd1, 1'b1, 5'd1, MD_ALU, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_over_accept: got ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_div();
    logic seen;
    out_ready = 1'b1;
    drive(1'b1, MOP_ALU, FS_ADD, 32'd5, 32'd7, 1'b1, 5'd4, MD_DATA, 32'h0000_00AA);
    tick();
    drive(1'b1, MOP_DIVU, FS_ADD, 32'd100, 32'd7, 1'b1, 5'd8, MD_ALU, 32'd0);
    tick();
    in_valid = 1'b0;
    total++;
    if (result !== 32'd12 || DA_WB !== 5'd4 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_pre: got res=%h da=%h rdy=%b want 0000000c 04 0", result, DA_WB, in_ready);
    end
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, RW_WB, DA_WB, MD_WB, determinate} !== 10'd0 || result !== 32'd0 ||
        DData_next !== 32'd0) begin
      bad++;
      $display("FAIL rst_async: got ov=%b rw=%b da=%h md=%h det=%b res=%h dd=%h want all 0",
               out_valid, RW_WB, DA_WB, MD_WB, determinate, result, DData_next);
    end
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL rst_no_stale: got stale/blocked=%b want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_alu_add();
    test_slt_zero();
    test_muldiv(MOP_MUL,  32'h0001_0003, 32'h0001_0002, 32'h0005_0006);
    test_muldiv(MOP_DIVU, 32'd100, 32'd7, 32'd14);
    test_muldiv(MOP_REMU, 32'd100, 32'd7, 32'd2);
    test_muldiv(MOP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF);
    test_muldiv(MOP_REMU, 32'd9, 32'd0, 32'd9);
    test_back_pressure();
    test_flush();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
